fetch_predict_unit: RTL and testbench

//   Parametrised fetch stage for the pipelined RV core: PC register, next-PC select, direct-mapped

---
 rtl/rv_pipe_pkg.sv | 38 +++
 rtl/fetch_btb.sv | 82 ++++++++
 rtl/fetch_predict_unit.sv | 114 +++++++++++
 tb/tb_fetch_predict_unit.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pipe_pkg.sv
// rtl/rv_pipe_pkg.sv - shared pipeline types and constants for the RV core
// Contents: default XLEN, 2-bit branch counter encodings with saturating
// step helpers, and the canonical NOP encoding.
package rv_pipe_pkg;

  localparam int RV_XLEN = 32;

  // 2-bit branch direction counter: upper bit is the taken prediction.
  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic ctr_e ctr_inc(input ctr_e c);
    case (c)
      CTR_SNT: return CTR_WNT;
      CTR_WNT: return CTR_WT;
      default: return CTR_ST;
    endcase
  endfunction

  function automatic ctr_e ctr_dec(input ctr_e c);
    case (c)
      CTR_ST:  return CTR_WT;
      CTR_WT:  return CTR_WNT;
      default: return CTR_SNT;
    endcase
  endfunction

  function automatic logic ctr_taken(input ctr_e c);
    return c[1];
  endfunction

endpackage

// File: rtl/fetch_btb.sv
// rtl/fetch_btb.sv - direct-mapped branch target buffer with 2-bit counters
// Ports:
//   clk_i, reset_i    clock, synchronous active-high reset
//   lookup_word_i     fetch PC without bits [1:0]
//   lookup_taken_o    hit and counter predicts taken
//   lookup_target_o   stored target of the indexed entry
//   upd_en_i          a resolved branch/jump updates the table this edge
//   upd_word_i        resolving PC without bits [1:0]
//   upd_taken_i       actual outcome
//   upd_target_i      actual target
module fetch_btb
  import rv_pipe_pkg::*;
#(
  parameter int XLEN        = RV_XLEN,
  parameter int BTB_ENTRIES = 16
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic [XLEN-3:0] lookup_word_i,
  output logic            lookup_taken_o,
  output logic [XLEN-1:0] lookup_target_o,
  input  logic            upd_en_i,
  input  logic [XLEN-3:0] upd_word_i,
  input  logic            upd_taken_i,
  input  logic [XLEN-1:0] upd_target_i
);

  localparam int IDXW = $clog2(BTB_ENTRIES);
  localparam int TAGW = XLEN - 2 - IDXW;

  logic [BTB_ENTRIES-1:0] valid_q;
  logic [TAGW-1:0]        tag_q    [BTB_ENTRIES];
  logic [XLEN-1:0]        target_q [BTB_ENTRIES];
  ctr_e                   ctr_q    [BTB_ENTRIES];

  logic [IDXW-1:0] lk_idx, up_idx;
  logic [TAGW-1:0] lk_tag, up_tag;
  logic            lk_hit, up_hit, up_write;
  ctr_e            up_ctr_d;

  assign lk_idx = lookup_word_i[IDXW-1:0];
  assign lk_tag = lookup_word_i[XLEN-3:IDXW];
  assign up_idx = upd_word_i[IDXW-1:0];
  assign up_tag = upd_word_i[XLEN-3:IDXW];

  // Lookup reads registered state only, so a same-cycle update is not visible.
  assign lk_hit          = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lookup_taken_o  = lk_hit && ctr_taken(ctr_q[lk_idx]);
  assign lookup_target_o = target_q[lk_idx];

  always_comb begin
    up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    up_write = 1'b0;
    up_ctr_d = ctr_q[up_idx];
    if (upd_taken_i) begin
      // Taken: a miss (re)allocates as weakly taken, a hit refreshes the target.
      up_write = 1'b1;
      up_ctr_d = up_hit ? ctr_inc(ctr_q[up_idx]) : CTR_WT;
    end else if (up_hit) begin
      up_ctr_d = ctr_dec(ctr_q[up_idx]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else if (upd_en_i) begin
      ctr_q[up_idx] <= up_ctr_d;
      if (up_write) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= upd_target_i;
      end
    end
  end

endmodule

// File: rtl/fetch_predict_unit.sv
// rtl/fetch_predict_unit.sv - fetch stage: PC, next-PC select, BTB prediction, F/D register
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   StallF, StallD, FlushD          hazard controls for PC and F/D register
//   InstrF                          instruction at PCF from imem
//   PCF                             current fetch PC
//   InstrD, PCD, PCPlus4D           decode-stage instruction, PC, PC+4
//   PredTakenD, PredTargetD, ValidD prediction carried with InstrD, bubble flag
//   ResolveE, TakenE, TargetE, PCE  E-stage branch/jump resolution
//   PredTakenE, PredTargetE         prediction carried down to E
//   MispredictE                     combinational redirect/flush request
module fetch_predict_unit
  import rv_pipe_pkg::*;
#(
  parameter int              XLEN        = RV_XLEN,
  parameter int              BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter bit              PREDICT_EN  = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic [31:0]     InstrF,
  output logic [XLEN-1:0] PCF,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            PredTakenD,
  output logic [XLEN-1:0] PredTargetD,
  output logic            ValidD,
  input  logic            ResolveE,
  input  logic            TakenE,
  input  logic [XLEN-1:0] TargetE,
  input  logic [XLEN-1:0] PCE,
  input  logic            PredTakenE,
  input  logic [XLEN-1:0] PredTargetE,
  output logic            MispredictE
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4_f, pc_plus4_e;
  logic            btb_taken, pred_taken_f;
  logic [XLEN-1:0] btb_target;

  logic [31:0]     instr_fd_q;
  logic [XLEN-1:0] pc_fd_q, pc4_fd_q, pred_target_fd_q;
  logic            pred_taken_fd_q, valid_fd_q;

  fetch_btb #(
    .XLEN        (XLEN),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk_i           (clk),
    .reset_i         (reset),
    .lookup_word_i   (pc_q[XLEN-1:2]),
    .lookup_taken_o  (btb_taken),
    .lookup_target_o (btb_target),
    .upd_en_i        (ResolveE && PREDICT_EN),
    .upd_word_i      (PCE[XLEN-1:2]),
    .upd_taken_i     (TakenE),
    .upd_target_i    (TargetE)
  );

  assign pred_taken_f = PREDICT_EN && btb_taken;
  assign pc_plus4_f   = pc_q + XLEN'(4);
  assign pc_plus4_e   = PCE + XLEN'(4);

  // A predicted-taken branch is also wrong when it jumped to a stale target (jalr).
  assign MispredictE = ResolveE &&
                       ((TakenE != PredTakenE) || (TakenE && (TargetE != PredTargetE)));

  // Redirect beats StallF: the stalled fetch is on the wrong path anyway.
  always_comb begin
    pc_d = pc_plus4_f;
    if (MispredictE)       pc_d = TakenE ? TargetE : pc_plus4_e;
    else if (StallF)       pc_d = pc_q;
    else if (pred_taken_f) pc_d = btb_target;
  end

  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  // Clear beats StallD so a wrong-path instruction never survives a stall.
  always_ff @(posedge clk) begin
    if (reset || FlushD || MispredictE) begin
      instr_fd_q       <= '0;
      pc_fd_q          <= '0;
      pc4_fd_q         <= '0;
      pred_taken_fd_q  <= 1'b0;
      pred_target_fd_q <= '0;
      valid_fd_q       <= 1'b0;
    end else if (!StallD) begin
      instr_fd_q       <= InstrF;
      pc_fd_q          <= pc_q;
      pc4_fd_q         <= pc_plus4_f;
      pred_taken_fd_q  <= pred_taken_f;
      pred_target_fd_q <= btb_target;
      valid_fd_q       <= 1'b1;
    end
  end

  assign PCF         = pc_q;
  assign InstrD      = instr_fd_q;
  assign PCD         = pc_fd_q;
  assign PCPlus4D    = pc4_fd_q;
  assign PredTakenD  = pred_taken_fd_q;
  assign PredTargetD = pred_target_fd_q;
  assign ValidD      = valid_fd_q;

endmodule

// File: tb/tb_fetch_predict_unit.sv
// tb/tb_fetch_predict_unit.sv - directed scoreboard bench for fetch_predict_unit
module tb_fetch_predict_unit;

  logic clk;
  logic reset, StallF, StallD, FlushD;

  // Instance A: default parameters
  logic [31:0] InstrF_a, PCF_a, InstrD_a, PCD_a, PCPlus4D_a, PredTargetD_a;
  logic        PredTakenD_a, ValidD_a, MispredictE_a;
  logic        ResolveE_a, TakenE_a, PredTakenE_a;
  logic [31:0] TargetE_a, PCE_a, PredTargetE_a;

  // Instances B (4 entries, predicting) and C (4 entries, static) share E inputs
  logic        ResolveE_s, TakenE_s, PredTakenE_s;
  logic [31:0] TargetE_s, PCE_s, PredTargetE_s;
  logic [31:0] InstrF_b, PCF_b, InstrD_b, PCD_b, PCPlus4D_b, PredTargetD_b;
  logic        PredTakenD_b, ValidD_b, MispredictE_b;
  logic [31:0] InstrF_c, PCF_c, InstrD_c, PCD_c, PCPlus4D_c, PredTargetD_c;
  logic        PredTakenD_c, ValidD_c, MispredictE_c;

  assign InstrF_a = 32'hA000_0000 | PCF_a;
  assign InstrF_b = 32'hB000_0000 | PCF_b;
  assign InstrF_c = 32'hC000_0000 | PCF_c;

  fetch_predict_unit u_dut_a (
    .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .InstrF(InstrF_a), .PCF(PCF_a), .InstrD(InstrD_a), .PCD(PCD_a), .PCPlus4D(PCPlus4D_a),
    .PredTakenD(PredTakenD_a), .PredTargetD(PredTargetD_a), .ValidD(ValidD_a),
    .ResolveE(ResolveE_a), .TakenE(TakenE_a), .TargetE(TargetE_a), .PCE(PCE_a),
    .PredTakenE(PredTakenE_a), .PredTargetE(PredTargetE_a), .MispredictE(MispredictE_a)
  );

  fetch_predict_unit #(.BTB_ENTRIES(4), .PREDICT_EN(1'b1)) u_dut_b (
    .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .InstrF(InstrF_b), .PCF(PCF_b), .InstrD(InstrD_b), .PCD(PCD_b), .PCPlus4D(PCPlus4D_b),
    .PredTakenD(PredTakenD_b), .PredTargetD(PredTargetD_b), .ValidD(ValidD_b),
    .ResolveE(ResolveE_s), .TakenE(TakenE_s), .TargetE(TargetE_s), .PCE(PCE_s),
    .PredTakenE(PredTakenE_s), .PredTargetE(PredTargetE_s), .MispredictE(MispredictE_b)
  );

  fetch_predict_unit #(.BTB_ENTRIES(4), .PREDICT_EN(1'b0)) u_dut_c (
    .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .InstrF(InstrF_c), .PCF(PCF_c), .InstrD(InstrD_c), .PCD(PCD_c), .PCPlus4D(PCPlus4D_c),
    .PredTakenD(PredTakenD_c), .PredTargetD(PredTargetD_c), .ValidD(ValidD_c),
    .ResolveE(ResolveE_s), .TakenE(TakenE_s), .TargetE(TargetE_s), .PCE(PCE_s),
    .PredTakenE(PredTakenE_s), .PredTargetE(PredTargetE_s), .MispredictE(MispredictE_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int A_PCF = 0, A_VALID = 1, A_PCD = 2, A_PC4D = 3, A_INSTRD = 4;
  localparam int A_PTD = 5, A_PTGD = 6, A_MISP = 7;
  localparam int B_PCF = 8, B_PTD = 9, C_PCF = 10, C_PTD = 11, C_MISP = 12;

  typedef struct {
    int          sig;
    logic [63:0] val;
    string       tag;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [63:0] observe(input int sig);
    case (sig)
      A_PCF:    return {32'b0, PCF_a};
      A_VALID:  return {63'b0, ValidD_a};
      A_PCD:    return {32'b0, PCD_a};
      A_PC4D:   return {32'b0, PCPlus4D_a};
      A_INSTRD: return {32'b0, InstrD_a};
      A_PTD:    return {63'b0, PredTakenD_a};
      A_PTGD:   return {32'b0, PredTargetD_a};
      A_MISP:   return {63'b0, MispredictE_a};
      B_PCF:    return {32'b0, PCF_b};
      B_PTD:    return {63'b0, PredTakenD_b};
      C_PCF:    return {32'b0, PCF_c};
      C_PTD:    return {63'b0, PredTakenD_c};
      C_MISP:   return {63'b0, MispredictE_c};
      default:  return 64'hDEAD_DEAD_DEAD_DEAD;
    endcase
  endfunction

  task automatic push_exp(input int sig, input logic [63:0] val, input string tag);
    exp_t x;
    x.sig = sig;
    x.val = val;
    x.tag = tag;
    q.push_back(x);
  endtask

  task automatic drain();
    exp_t x;
    logic [63:0] obs;
    while (q.size() != 0) begin
      x = q.pop_front();
      obs = observe(x.sig);
      checks++;
      assert (obs === x.val) else begin
        errors++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", x.tag, obs, x.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic settle();
    #1;
    drain();
  endtask

  task automatic resolve_a(input logic tk, input logic [31:0] tgt, input logic [31:0] pce,
                           input logic ptk, input logic [31:0] ptgt);
    ResolveE_a = 1'b1; TakenE_a = tk; TargetE_a = tgt; PCE_a = pce;
    PredTakenE_a = ptk; PredTargetE_a = ptgt;
  endtask

  task automatic idle_a();
    ResolveE_a = 1'b0; TakenE_a = 1'b0; TargetE_a = '0; PCE_a = '0;
    PredTakenE_a = 1'b0; PredTargetE_a = '0;
  endtask

  task automatic resolve_s(input logic tk, input logic [31:0] tgt, input logic [31:0] pce,
                           input logic ptk, input logic [31:0] ptgt);
    ResolveE_s = 1'b1; TakenE_s = tk; TargetE_s = tgt; PCE_s = pce;
    PredTakenE_s = ptk; PredTargetE_s = ptgt;
  endtask

  task automatic idle_s();
    ResolveE_s = 1'b0; TakenE_s = 1'b0; TargetE_s = '0; PCE_s = '0;
    PredTakenE_s = 1'b0; PredTargetE_s = '0;
  endtask

  initial begin
    reset = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    idle_a();
    idle_s();
    tick();
    push_exp(A_PCF, 0, "rst_pcf");
    push_exp(A_VALID, 0, "rst_valid");
    push_exp(A_INSTRD, 0, "rst_instrd");
    push_exp(A_PCD, 0, "rst_pcd");
    push_exp(A_PC4D, 0, "rst_pc4d");
    push_exp(A_PTD, 0, "rst_ptd");
    push_exp(A_PTGD, 0, "rst_ptgd");
    tick();
    reset = 1'b0;

    // Free run from reset
    push_exp(A_PCF, 4, "run_pcf4");
    push_exp(A_VALID, 1, "run_valid");
    push_exp(A_PCD, 0, "run_pcd0");
    push_exp(A_PC4D, 4, "run_pc4d");
    push_exp(A_INSTRD, 32'hA000_0000, "run_instrd");
    tick();
    push_exp(A_PCF, 8, "run_pcf8");
    push_exp(A_PCD, 4, "run_pcd4");
    tick();
    push_exp(A_PCF, 'hC, "run_pcfc");
    push_exp(A_PCD, 8, "run_pcd8");
    tick();
    push_exp(A_PCF, 'h10, "run_pcf10");
    tick();
    push_exp(A_PCF, 'h14, "cold_miss");
    tick();

    // Branch at 0x10 taken to 0x40, first time
    resolve_a(1'b1, 'h40, 'h10, 1'b0, 0);
    push_exp(A_MISP, 1, "first_taken_misp");
    settle();
    push_exp(A_PCF, 'h40, "first_redirect");
    push_exp(A_VALID, 0, "first_flush");
    tick();
    resolve_a(1'b1, 'h10, 'h3C, 1'b0, 0);
    push_exp(A_PCF, 'h10, "back_to_10");
    tick();
    idle_a();
    push_exp(A_PCF, 'h40, "pred_redirect");
    push_exp(A_PTD, 1, "pred_taken_d");
    push_exp(A_PTGD, 'h40, "pred_target_d");
    push_exp(A_PCD, 'h10, "pred_pcd");
    push_exp(A_VALID, 1, "pred_valid");
    tick();

    // Loop branch: two more correct taken resolutions, then fall-through
    resolve_a(1'b1, 'h40, 'h10, 1'b1, 'h40);
    push_exp(A_MISP, 0, "loop_taken2");
    settle();
    push_exp(A_PCF, 'h44, "loop_pcf44");
    tick();
    resolve_a(1'b1, 'h40, 'h10, 1'b1, 'h40);
    push_exp(A_MISP, 0, "loop_taken3");
    settle();
    push_exp(A_PCF, 'h48, "loop_pcf48");
    tick();
    resolve_a(1'b0, 'h40, 'h10, 1'b1, 'h40);
    push_exp(A_MISP, 1, "fallthru_misp");
    settle();
    push_exp(A_PCF, 'h14, "fallthru_pc");
    push_exp(A_VALID, 0, "fallthru_flush");
    tick();
    resolve_a(1'b1, 'h10, 'h3C, 1'b0, 0);
    push_exp(A_PCF, 'h10, "revisit_10");
    tick();
    idle_a();
    push_exp(A_PCF, 'h40, "still_taken");
    push_exp(A_PTD, 1, "still_taken_d");
    tick();

    // jalr at 0x60 whose target moves from 0x80 to 0xC0
    resolve_a(1'b1, 'h80, 'h60, 1'b0, 0);
    push_exp(A_PCF, 'h80, "jalr_first");
    tick();
    resolve_a(1'b1, 'hC0, 'h60, 1'b1, 'h80);
    push_exp(A_MISP, 1, "jalr_tgt_misp");
    settle();
    push_exp(A_PCF, 'hC0, "jalr_redirect");
    tick();
    resolve_a(1'b1, 'h60, 'h200, 1'b0, 0);
    push_exp(A_PCF, 'h60, "goto_60");
    tick();
    idle_a();
    push_exp(A_PCF, 'hC0, "jalr_new_tgt");
    push_exp(A_PTGD, 'hC0, "jalr_ptgd");
    push_exp(A_PTD, 1, "jalr_ptd");
    tick();

    // PC+4 wraps modulo 2^32
    resolve_a(1'b1, 32'hFFFF_FFFC, 'h400, 1'b0, 0);
    push_exp(A_PCF, 32'hFFFF_FFFC, "goto_top");
    tick();
    idle_a();
    push_exp(A_PCF, 0, "wrap_pcf");
    push_exp(A_PCD, 32'hFFFF_FFFC, "wrap_pcd");
    push_exp(A_PC4D, 0, "wrap_pc4d");
    tick();

    // Redirect and clear win over stalls; stalls hold otherwise
    StallF = 1'b1; StallD = 1'b1;
    resolve_a(1'b0, 0, 'h300, 1'b1, 'h123);
    push_exp(A_MISP, 1, "stall_misp");
    settle();
    push_exp(A_PCF, 'h304, "stall_redirect");
    push_exp(A_VALID, 0, "stall_clear");
    tick();
    idle_a();
    push_exp(A_PCF, 'h304, "stallf_hold");
    push_exp(A_VALID, 0, "stalld_hold_bubble");
    tick();
    StallF = 1'b0; StallD = 1'b0;
    push_exp(A_PCF, 'h308, "unstall_pcf");
    push_exp(A_VALID, 1, "unstall_valid");
    push_exp(A_PCD, 'h304, "unstall_pcd");
    tick();
    StallF = 1'b1; StallD = 1'b1;
    push_exp(A_PCF, 'h308, "hold_pcf");
    push_exp(A_PCD, 'h304, "hold_pcd");
    push_exp(A_VALID, 1, "hold_valid");
    tick();
    FlushD = 1'b1;
    push_exp(A_VALID, 0, "flush_beats_stall");
    push_exp(A_PCF, 'h308, "flush_pcf_hold");
    tick();
    FlushD = 1'b0; StallF = 1'b0; StallD = 1'b0;

    // Mid-operation reset clears the BTB
    reset = 1'b1;
    push_exp(A_PCF, 0, "rst2_pcf");
    push_exp(A_VALID, 0, "rst2_valid");
    tick();
    reset = 1'b0;
    push_exp(A_PCF, 4, "rst2_run4");
    tick();
    push_exp(A_PCF, 8, "rst2_run8");
    tick();
    push_exp(A_PCF, 'hC, "rst2_runc");
    tick();
    push_exp(A_PCF, 'h10, "rst2_run10");
    tick();
    push_exp(A_PCF, 'h14, "btb_cleared");
    push_exp(A_PTD, 0, "btb_cleared_ptd");
    tick();

    // B and C are both at 0x14 with empty tables: repeated taken branch 0x10->0x40
    for (int k = 0; k < 2; k++) begin
      resolve_s(1'b1, 'h40, 'h10, 1'b0, 0);
      push_exp(C_MISP, 1, "static_misp");
      settle();
      push_exp(C_PCF, 'h40, "static_redirect");
      push_exp(B_PCF, 'h40, "b_redirect");
      tick();
      resolve_s(1'b1, 'h10, 'h3C, 1'b0, 0);
      push_exp(B_PCF, 'h10, "b_goto_10");
      push_exp(C_PCF, 'h10, "c_goto_10");
      tick();
      idle_s();
      push_exp(C_PCF, 'h14, "static_fallthru");
      push_exp(C_PTD, 0, "static_ptd");
      push_exp(B_PCF, 'h40, "b_pred");
      push_exp(B_PTD, 1, "b_pred_d");
      tick();
    end

    // Aliasing on B: 0x20 shares index 0 with 0x10
    resolve_s(1'b1, 'h20, 'h3C, 1'b0, 0);
    push_exp(B_PCF, 'h20, "b_goto_20");
    tick();
    idle_s();
    push_exp(B_PCF, 'h24, "alias_no_false_hit");
    push_exp(B_PTD, 0, "alias_no_false_hit_d");
    tick();
    resolve_s(1'b1, 'h80, 'h20, 1'b0, 0);
    push_exp(B_PCF, 'h80, "alias_alloc");
    tick();
    resolve_s(1'b1, 'h10, 'h3C, 1'b0, 0);
    push_exp(B_PCF, 'h10, "b_goto_10b");
    tick();
    idle_s();
    push_exp(B_PCF, 'h14, "alias_evicted");
    push_exp(B_PTD, 0, "alias_evicted_d");
    tick();
    resolve_s(1'b1, 'h20, 'h3C, 1'b0, 0);
    push_exp(B_PCF, 'h20, "b_goto_20b");
    tick();
    idle_s();
    push_exp(B_PCF, 'h80, "alias_new_entry");
    push_exp(B_PTD, 1, "alias_new_entry_d");
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
